// File: rtl/mips_multicycle_ctrl_if.sv
// Control bundle between the multicycle MIPS controller (master) and the datapath/memory side (slave).
interface mips_multicycle_ctrl_if;
    logic [5:0]  op;
    logic [5:0]  funct;
    logic        zero;
    logic        mem_ready;
    logic        mem_req;
    logic        i_or_d;
    logic        mem_write;
    logic        ir_write;
    logic        pc_en;
    logic [1:0]  pc_src;
    logic        alu_src_a;
    logic [1:0]  alu_src_b;
    logic [2:0]  alu_control;
    logic        reg_write;
    logic [1:0]  reg_dst;
    logic [1:0]  wd_src;
    logic        halted;
    logic [31:0] retired;

    modport master (
        input  op, funct, zero, mem_ready,
        output mem_req, i_or_d, mem_write, ir_write, pc_en, pc_src,
               alu_src_a, alu_src_b, alu_control, reg_write, reg_dst,
               wd_src, halted, retired
    );

    modport slave (
        output op, funct, zero, mem_ready,
        input  mem_req, i_or_d, mem_write, ir_write, pc_en, pc_src,
               alu_src_a, alu_src_b, alu_control, reg_write, reg_dst,
               wd_src, halted, retired
    );
endinterface

// File: rtl/mips_multicycle_ctrl.sv
// Multicycle MIPS control FSM: shares one ALU and one memory port across 3-5 states per
// instruction, waits on a req/ready memory handshake and counts retired instructions.
module mips_multicycle_ctrl (
    input  logic                          clk,
    input  logic                          reset,
    mips_multicycle_ctrl_if.master        bus
);

    typedef enum logic [3:0] {
        FETCH  = 4'd0,
        DECODE = 4'd1,
        MEMADR = 4'd2,
        MEMRD  = 4'd3,
        MEMWB  = 4'd4,
        MEMWR  = 4'd5,
        EXEC   = 4'd6,
        ALUWB  = 4'd7,
        BRANCH = 4'd8,
        IMMEX  = 4'd9,
        IMMWB  = 4'd10,
        JUMP   = 4'd11,
        HALT   = 4'd12
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_JAL   = 6'b000011;

    localparam logic [5:0] FN_ADD = 6'b100000;
    localparam logic [5:0] FN_SUB = 6'b100010;
    localparam logic [5:0] FN_AND = 6'b100100;
    localparam logic [5:0] FN_OR  = 6'b100101;
    localparam logic [5:0] FN_SLT = 6'b101010;

    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_SLT = 3'b111;

    state_t      state;
    state_t      state_next;
    state_t      dec_state;
    logic [31:0] retired_q;
    logic        retire;
    logic        funct_legal;
    logic [2:0]  funct_alu;

    // NOTE: every variable written in an always_comb gets a default first, so no path can infer a latch.
    always_comb begin
        funct_legal = 1'b1;
        funct_alu   = ALU_ADD;
        case (bus.funct)
            FN_ADD:  funct_alu = ALU_ADD;
            FN_SUB:  funct_alu = ALU_SUB;
            FN_AND:  funct_alu = ALU_AND;
            FN_OR:   funct_alu = ALU_OR;
            FN_SLT:  funct_alu = ALU_SLT;
            default: funct_legal = 1'b0;
        endcase
    end

    always_comb begin
        state_next = state;
        case (state)
            FETCH:  if (bus.mem_ready) state_next = DECODE;
            DECODE: begin
                case (bus.op)
                    OP_LW, OP_SW:     state_next = MEMADR;
                    OP_RTYPE:         state_next = funct_legal ? EXEC : HALT;
                    OP_BEQ, OP_BNE:   state_next = BRANCH;
                    OP_ADDI, OP_ANDI: state_next = IMMEX;
                    OP_J, OP_JAL:     state_next = JUMP;
                    default:          state_next = HALT;
                endcase
            end
            MEMADR: state_next = (bus.op == OP_SW) ? MEMWR : MEMRD;
            MEMRD:  if (bus.mem_ready) state_next = MEMWB;
            MEMWB:  state_next = FETCH;
            MEMWR:  if (bus.mem_ready) state_next = FETCH;
            EXEC:   state_next = ALUWB;
            ALUWB:  state_next = FETCH;
            BRANCH: state_next = FETCH;
            IMMEX:  state_next = IMMWB;
            IMMWB:  state_next = FETCH;
            JUMP:   state_next = FETCH;
            HALT:   state_next = HALT;
            default: state_next = FETCH;
        endcase
    end

    // An instruction retires when it hands control back to FETCH; a FETCH wait is not a hand-back.
    assign retire = (state_next == FETCH) && (state != FETCH) && (state != HALT);

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= FETCH;
            retired_q <= '0;
        end else begin
            state     <= state_next;
            retired_q <= retired_q + 32'(retire);
        end
    end

    // While reset is high the outputs look like FETCH, with every strobe held low.
    assign dec_state = reset ? FETCH : state;

    always_comb begin
        bus.mem_req     = 1'b0;
        bus.i_or_d      = 1'b0;
        bus.mem_write   = 1'b0;
        bus.ir_write    = 1'b0;
        bus.pc_en       = 1'b0;
        bus.pc_src      = 2'b00;
        bus.alu_src_a   = 1'b0;
        bus.alu_src_b   = 2'b00;
        bus.alu_control = 3'b000;
        bus.reg_write   = 1'b0;
        bus.reg_dst     = 2'b00;
        bus.wd_src      = 2'b00;
        bus.halted      = 1'b0;
        case (dec_state)
            FETCH: begin
                bus.mem_req     = 1'b1;
                bus.alu_src_b   = 2'b01;
                bus.alu_control = ALU_ADD;
                bus.ir_write    = bus.mem_ready;
                bus.pc_en       = bus.mem_ready;
            end
            DECODE: begin
                bus.alu_src_b   = 2'b11;
                bus.alu_control = ALU_ADD;
            end
            MEMADR: begin
                bus.alu_src_a   = 1'b1;
                bus.alu_src_b   = 2'b10;
                bus.alu_control = ALU_ADD;
            end
            MEMRD: begin
                bus.mem_req = 1'b1;
                bus.i_or_d  = 1'b1;
            end
            MEMWB: begin
                bus.reg_write = 1'b1;
                bus.wd_src    = 2'b01;
            end
            MEMWR: begin
                bus.mem_req   = 1'b1;
                bus.i_or_d    = 1'b1;
                bus.mem_write = bus.mem_ready;
            end
            EXEC: begin
                bus.alu_src_a   = 1'b1;
                bus.alu_control = funct_alu;
            end
            ALUWB: begin
                bus.reg_write = 1'b1;
                bus.reg_dst   = 2'b01;
            end
            BRANCH: begin
                bus.alu_src_a   = 1'b1;
                bus.alu_control = ALU_SUB;
                bus.pc_src      = 2'b01;
                bus.pc_en       = (bus.op == OP_BNE) ? ~bus.zero : bus.zero;
            end
            IMMEX: begin
                bus.alu_src_a   = 1'b1;
                bus.alu_src_b   = 2'b10;
                bus.alu_control = (bus.op == OP_ANDI) ? ALU_AND : ALU_ADD;
            end
            IMMWB: begin
                bus.reg_write = 1'b1;
            end
            JUMP: begin
                bus.pc_src = 2'b10;
                bus.pc_en  = 1'b1;
                // PC already holds PC+4 here, so it is the correct link value for jal.
                if (bus.op == OP_JAL) begin
                    bus.reg_write = 1'b1;
                    bus.reg_dst   = 2'b10;
                    bus.wd_src    = 2'b10;
                end
            end
            HALT:    bus.halted = 1'b1;
            default: ;
        endcase
        if (reset) begin
            bus.pc_en     = 1'b0;
            bus.ir_write  = 1'b0;
            bus.mem_write = 1'b0;
            bus.reg_write = 1'b0;
        end
    end

    assign bus.retired = retired_q;

endmodule
